// File: rtl/significand_pipe.sv
// significand_pipe: three-stage valid/ready significand datapath for the FPU multiplier.
// S1 multiplies the significands, S2 normalises and folds the low bits into guard/sticky,
// S3 applies the rounding mode and holds the result for the exponent adjust/pack stage.
module significand_pipe #(
  parameter int MW = 23,
  parameter int SW = $clog2(2*MW+2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW:0]   Mx,
  input  logic [MW:0]   My,
  input  logic [1:0]    R_mode,
  input  logic          Sz,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] Mz,
  output logic          ovf,
  output logic [SW-1:0] SHL,
  output logic          Overflow_after_round
);

  localparam int PW = 2*MW + 2;

  // Stage occupancy and load strobes
  logic s1Load, s2Load, s3Load;
  logic s1Valid_q, s1Valid_d;
  logic s2Valid_q, s2Valid_d;
  logic s3Valid_q, s3Valid_d;

  // S1 contents: raw product plus the rounding context that travels with it
  logic [PW-1:0] product;
  logic [PW-1:0] s1P_q;
  logic [1:0]    s1Mode_q;
  logic          s1Sz_q;

  // S2 contents: normalised significand, guard, sticky and normalisation flags
  int            lzCount;
  logic          lzFound;
  logic [PW-1:0] normQ;
  logic [MW:0]   s2Sig_d, s2Sig_q;
  logic          s2Guard_d, s2Guard_q;
  logic          s2Sticky_d, s2Sticky_q;
  logic          s2Ovf_d, s2Ovf_q;
  logic [SW-1:0] s2Shl_d, s2Shl_q;
  logic [1:0]    s2Mode_q;
  logic          s2Sz_q;

  // S3 contents: the registered result seen on the output ports
  logic          roundInc;
  logic [MW-1:0] mz_d, mz_q;
  logic          roundCarry_d, roundCarry_q;
  logic          ovf_q;
  logic [SW-1:0] shl_q;

  // Each stage loads when its upstream beat is valid and it is empty or its own beat is leaving.
  // The ready chain is combinational from out_ready back to in_ready.
  assign s3Load   = s2Valid_q && (!s3Valid_q || out_ready);
  assign s2Load   = s1Valid_q && (!s2Valid_q || s3Load);
  assign in_ready = !s1Valid_q || s2Load;
  assign s1Load   = in_valid && in_ready;

  // Zero-extend both operands so the multiply is evaluated at full product width.
  assign product = {{(MW+1){1'b0}}, Mx} * {{(MW+1){1'b0}}, My};

  // A stage stays occupied unless its beat moves on without a replacement arriving.
  always_comb begin
    s1Valid_d = s1Load || (s1Valid_q && !s2Load);
    s2Valid_d = s2Load || (s2Valid_q && !s3Load);
    s3Valid_d = s3Load || (s3Valid_q && !out_ready);
  end

  // Normalise the product: an MSB carry means ovf; otherwise shift past the leading one,
  // then split the top MW+1 bits off as the significand with guard and sticky below.
  always_comb begin
    lzCount    = 0;
    lzFound    = 1'b0;
    normQ      = '0;
    s2Ovf_d    = 1'b0;
    s2Shl_d    = '0;
    for (int i = PW-2; i >= 0; i--) begin
      if (!lzFound) begin
        if (s1P_q[i]) begin
          lzFound = 1'b1;
        end else begin
          lzCount = lzCount + 1;
        end
      end
    end
    if (s1P_q[PW-1]) begin
      s2Ovf_d = 1'b1;
      normQ   = s1P_q;
    end else if (lzFound) begin
      s2Shl_d = SW'(lzCount);
      normQ   = s1P_q << (lzCount + 1);
    end
    s2Sig_d    = normQ[PW-1 -: MW+1];
    s2Guard_d  = normQ[PW-MW-2];
    s2Sticky_d = |normQ[PW-MW-3:0];
  end

  // Pick the round increment from the mode, then add it to the fraction. The carry out of the
  // full significand only happens when every significand bit is one, in which case the
  // wrapped fraction is already all zeros.
  always_comb begin
    roundInc = 1'b0;
    case (s2Mode_q)
      2'b00:   roundInc = s2Guard_q & (s2Sticky_q | s2Sig_q[0]);
      2'b01:   roundInc = 1'b0;
      2'b10:   roundInc = ~s2Sz_q & (s2Guard_q | s2Sticky_q);
      default: roundInc = s2Sz_q & (s2Guard_q | s2Sticky_q);
    endcase
    mz_d         = s2Sig_q[MW-1:0] + {{(MW-1){1'b0}}, roundInc};
    roundCarry_d = (&s2Sig_q) & roundInc;
  end

  // Pipeline registers; reset empties every stage and clears the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q    <= 1'b0;
      s2Valid_q    <= 1'b0;
      s3Valid_q    <= 1'b0;
      s1P_q        <= '0;
      s1Mode_q     <= '0;
      s1Sz_q       <= 1'b0;
      s2Sig_q      <= '0;
      s2Guard_q    <= 1'b0;
      s2Sticky_q   <= 1'b0;
      s2Ovf_q      <= 1'b0;
      s2Shl_q      <= '0;
      s2Mode_q     <= '0;
      s2Sz_q       <= 1'b0;
      mz_q         <= '0;
      roundCarry_q <= 1'b0;
      ovf_q        <= 1'b0;
      shl_q        <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s2Valid_q <= s2Valid_d;
      s3Valid_q <= s3Valid_d;
      if (s1Load) begin
        s1P_q    <= product;
        s1Mode_q <= R_mode;
        s1Sz_q   <= Sz;
      end
      if (s2Load) begin
        s2Sig_q    <= s2Sig_d;
        s2Guard_q  <= s2Guard_d;
        s2Sticky_q <= s2Sticky_d;
        s2Ovf_q    <= s2Ovf_d;
        s2Shl_q    <= s2Shl_d;
        s2Mode_q   <= s1Mode_q;
        s2Sz_q     <= s1Sz_q;
      end
      if (s3Load) begin
        mz_q         <= mz_d;
        roundCarry_q <= roundCarry_d;
        ovf_q        <= s2Ovf_q;
        shl_q        <= s2Shl_q;
      end
    end
  end

  assign out_valid            = s3Valid_q;
  assign Mz                   = mz_q;
  assign ovf                  = ovf_q;
  assign SHL                  = shl_q;
  assign Overflow_after_round = roundCarry_q;

endmodule

// File: tb/tb_significand_pipe.sv
// tb_significand_pipe: directed vectors for significand_pipe at MW=23 with an arithmetic
// reference model and a scoreboard that follows every handshake.
module tb_significand_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] Mx;
  logic [23:0] My;
  logic [1:0]  R_mode;
  logic        Sz;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] Mz;
  logic        ovf;
  logic [5:0]  SHL;
  logic        Overflow_after_round;

  typedef struct packed {
    logic [22:0] mz;
    logic        ovf;
    logic [5:0]  shl;
    logic        oar;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;
  logic randomReady;
  logic holdValid;
  logic [31:0] heldWord;

  significand_pipe #(.MW(23)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .Mx                   (Mx),
    .My                   (My),
    .R_mode               (R_mode),
    .Sz                   (Sz),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .Mz                   (Mz),
    .ovf                  (ovf),
    .SHL                  (SHL),
    .Overflow_after_round (Overflow_after_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic on the product value
  function automatic exp_t model(input logic [23:0] mx, input logic [23:0] my,
                                 input logic [1:0] mode, input logic sz);
    longint unsigned a, b, p, q, s, r;
    int   shl;
    logic ov, g, t, inc;
    exp_t e;
    a   = 64'(mx);
    b   = 64'(my);
    p   = a * b;
    shl = 0;
    ov  = 1'b0;
    if (p == 0) begin
      q = 0;
    end else if (p >= (64'd1 << 47)) begin
      ov = 1'b1;
      q  = p;
    end else begin
      q = p;
      while (q < (64'd1 << 46)) begin
        q   = q * 2;
        shl = shl + 1;
      end
      q = (q * 2) % (64'd1 << 48);
    end
    s = q / (64'd1 << 24);
    g = ((q / (64'd1 << 23)) % 2) != 0;
    t = (q % (64'd1 << 23)) != 0;
    case (mode)
      2'b00:   inc = g && (t || (s % 2 != 0));
      2'b01:   inc = 1'b0;
      2'b10:   inc = !sz && (g || t);
      default: inc = sz && (g || t);
    endcase
    r     = s + 64'(inc);
    e.oar = r >= (64'd1 << 24);
    e.mz  = 23'(r % (64'd1 << 23));
    e.ovf = ov;
    e.shl = 6'(shl);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Present one beat and hold it until the pipeline takes it; returns 1ns after the accepting edge
  task automatic applyStimulus(input logic [23:0] mx, input logic [23:0] my,
                               input logic [1:0] mode, input logic sz);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    Mx       = mx;
    My       = my;
    R_mode   = mode;
    Sz       = sz;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    checkOutput("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  // One beat through an idle pipeline with hand-computed expectations for both model and DUT
  task automatic directedCase(input string name, input logic [23:0] mx, input logic [23:0] my,
                              input logic [1:0] mode, input logic sz, input logic [22:0] expMz,
                              input logic expOvf, input logic [5:0] expShl, input logic expOar);
    exp_t e;
    int   lat;
    e = model(mx, my, mode, sz);
    checkOutput({name, "/model"}, 64'({e.mz, e.ovf, e.shl, e.oar}),
                64'({expMz, expOvf, expShl, expOar}));
    applyStimulus(mx, my, mode, sz);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    // The accepting edge is the first of the three edges a beat needs to reach the outputs
    checkOutput({name, "/edges"}, 64'(lat + 1), 64'd3);
    checkOutput({name, "/Mz"},  64'(Mz),  64'(expMz));
    checkOutput({name, "/ovf"}, 64'(ovf), 64'(expOvf));
    checkOutput({name, "/SHL"}, 64'(SHL), 64'(expShl));
    checkOutput({name, "/Overflow_after_round"}, 64'(Overflow_after_round), 64'(expOar));
  endtask

  // Randomly throttle the consumer while streaming
  always @(posedge clk) begin
    if (randomReady) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: track in-flight beats, compare each emitted beat and check stall behaviour
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      holdValid = 1'b0;
    end else begin
      checkOutput("in_ready_vs_occupancy", 64'(in_ready), 64'(!(sb.size() == 3 && !out_ready)));
      if (sb.size() == 3) checkOutput("out_valid_when_full", 64'(out_valid), 64'd1);
      if (sb.size() == 0) checkOutput("out_valid_when_empty", 64'(out_valid), 64'd0);
      if (holdValid)
        checkOutput("stalled_output_stable",
                    64'({out_valid, Mz, ovf, SHL, Overflow_after_round}), 64'(heldWord));
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("stream_result", 64'({Mz, ovf, SHL, Overflow_after_round}),
                    64'({e.mz, e.ovf, e.shl, e.oar}));
      end
      holdValid = out_valid && !out_ready;
      heldWord  = {out_valid, Mz, ovf, SHL, Overflow_after_round};
      if (in_valid && in_ready) sb.push_back(model(Mx, My, R_mode, Sz));
    end
  end

  logic [23:0] streamMx [8] = '{24'h800001, 24'hC00000, 24'hFFFFFE, 24'h400000,
                                24'hABCDEF, 24'h123456, 24'hFFFFFF, 24'h800000};
  logic [23:0] streamMy [8] = '{24'h800001, 24'hC00000, 24'h800001, 24'h800000,
                                24'h876543, 24'h9ABCDE, 24'hFFFFFF, 24'h000000};
  logic [1:0]  streamMd [8] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
  logic        streamSz [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int waited;
    compared    = 0;
    mismatched  = 0;
    randomReady = 1'b0;
    holdValid   = 1'b0;
    heldWord    = '0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    Mx          = '0;
    My          = '0;
    R_mode      = 2'b00;
    Sz          = 1'b0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset/out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset/in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset/Mz",        64'(Mz),        64'd0);
    checkOutput("reset/ovf",       64'(ovf),       64'd0);
    checkOutput("reset/SHL",       64'(SHL),       64'd0);
    checkOutput("reset/oar",       64'(Overflow_after_round), 64'd0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    directedCase("unity",       24'h800000, 24'h800000, 2'b00, 1'b0, 23'h000000, 1'b0, 6'd0, 1'b0);
    directedCase("prod_ovf",    24'hC00000, 24'hC00000, 2'b00, 1'b0, 23'h100000, 1'b1, 6'd0, 1'b0);
    directedCase("rtz",         24'h800001, 24'h800001, 2'b01, 1'b0, 23'h000002, 1'b0, 6'd0, 1'b0);
    directedCase("rne",         24'h800001, 24'h800001, 2'b00, 1'b0, 23'h000002, 1'b0, 6'd0, 1'b0);
    directedCase("rup_pos",     24'h800001, 24'h800001, 2'b10, 1'b0, 23'h000003, 1'b0, 6'd0, 1'b0);
    directedCase("rup_neg",     24'h800001, 24'h800001, 2'b10, 1'b1, 23'h000002, 1'b0, 6'd0, 1'b0);
    directedCase("rdn_pos",     24'h800001, 24'h800001, 2'b11, 1'b0, 23'h000002, 1'b0, 6'd0, 1'b0);
    directedCase("rdn_neg",     24'h800001, 24'h800001, 2'b11, 1'b1, 23'h000003, 1'b0, 6'd0, 1'b0);
    directedCase("round_carry", 24'hFFFFFE, 24'h800001, 2'b00, 1'b0, 23'h000000, 1'b0, 6'd0, 1'b1);
    directedCase("round_trunc", 24'hFFFFFE, 24'h800001, 2'b01, 1'b0, 23'h7FFFFF, 1'b0, 6'd0, 1'b0);
    directedCase("norm_shift",  24'h400000, 24'h800000, 2'b00, 1'b0, 23'h000000, 1'b0, 6'd1, 1'b0);
    directedCase("zero",        24'h000000, 24'h000000, 2'b10, 1'b0, 23'h000000, 1'b0, 6'd0, 1'b0);

    $display("[TB] streaming with random out_ready");
    randomReady = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(streamMx[i], streamMy[i], streamMd[i], streamSz[i]);
    waited = 0;
    while (sb.size() != 0 && waited < 500) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("stream_drain", 64'(sb.size()), 64'd0);
    randomReady = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] full pipeline stall");
    out_ready = 1'b0;
    applyStimulus(24'h800001, 24'h800001, 2'b10, 1'b0);
    applyStimulus(24'hC00000, 24'hC00000, 2'b00, 1'b0);
    applyStimulus(24'hFFFFFE, 24'h800001, 2'b00, 1'b0);
    in_valid = 1'b1;
    Mx       = 24'h400000;
    My       = 24'h800000;
    R_mode   = 2'b00;
    Sz       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stall/in_ready",  64'(in_ready),  64'd0);
    checkOutput("stall/out_valid", 64'(out_valid), 64'd1);
    checkOutput("stall/Mz",        64'(Mz),        64'h000003);
    out_ready = 1'b1;
    #1;
    checkOutput("release/in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stall_drain", 64'(sb.size()), 64'd0);

    $display("[TB] reset mid-stream");
    in_valid = 1'b1;
    Mx       = 24'hC00000;
    My       = 24'hC00000;
    @(posedge clk);
    #1;
    Mx = 24'hFFFFFE;
    My = 24'h800001;
    @(posedge clk);
    #1;
    rst = 1'b1;
    Mx  = 24'h800001;
    My  = 24'h800001;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("midreset/out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset/in_ready",  64'(in_ready),  64'd1);
    checkOutput("midreset/Mz",        64'(Mz),        64'd0);
    checkOutput("midreset/oar",       64'(Overflow_after_round), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("midreset/no_stale", 64'(out_valid), 64'd0);
    end
    directedCase("after_reset", 24'hC00000, 24'hC00000, 2'b00, 1'b0, 23'h100000, 1'b1, 6'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d mismatched %0d",
             compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
